// File: rtl/watch_dp_cfg.sv
// Parametrised time-of-day datapath: prescaler, sub-second/sec/min/hour cascade, load, adjust, 12 h view, alarm.
// Latency: every field, o_alarm and o_day_tick update on the edge after their cause; the 12 h view is combinational.
// Backpressure: none; strobes are consumed the cycle they are sampled, and i_run=0 freezes the prescaler phase.
module watch_dp_cfg #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SUB_RATE = 100,
    parameter int SUB_W    = $clog2(SUB_RATE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_mode12,
    input  logic             i_load,
    input  logic [4:0]       i_ld_hour,
    input  logic [5:0]       i_ld_min,
    input  logic [5:0]       i_ld_sec,
    input  logic             i_sec_up,
    input  logic             i_sec_down,
    input  logic             i_min_up,
    input  logic             i_min_down,
    input  logic             i_hour_up,
    input  logic             i_hour_down,
    input  logic             i_alarm_en,
    input  logic [4:0]       i_alarm_hour,
    input  logic [5:0]       i_alarm_min,
    output logic [SUB_W-1:0] o_sub,
    output logic [5:0]       o_sec,
    output logic [5:0]       o_min,
    output logic [4:0]       o_hour,
    output logic [4:0]       o_hour_disp,
    output logic             o_pm,
    output logic             o_alarm,
    output logic             o_day_tick
);

    localparam int DIV = CLK_FREQ / SUB_RATE;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SUB_RATE - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             alarm_q, alarm_d;
    logic             day_q, day_d;
    logic             blank_q;

    logic sub_tick, sub_wrap, sec_carry, min_carry, hour_carry, day_carry, adj_any;
    logic [5:0] sec_inc, min_inc;
    logic [4:0] hour_inc;

    function automatic logic [5:0] step60(input logic [5:0] v, input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up && !dn) begin
            r = (v == 6'd59) ? 6'd0 : v + 6'd1;
        end else if (dn && !up) begin
            r = (v == 6'd0) ? 6'd59 : v - 6'd1;
        end
        return r;
    endfunction

    function automatic logic [4:0] step24(input logic [4:0] v, input logic up, input logic dn);
        logic [4:0] r;
        r = v;
        if (up && !dn) begin
            r = (v == 5'd23) ? 5'd0 : v + 5'd1;
        end else if (dn && !up) begin
            r = (v == 5'd0) ? 5'd23 : v - 5'd1;
        end
        return r;
    endfunction

    assign sub_tick   = i_run && (presc_q == PRESC_LAST);
    assign sub_wrap   = (sub_q == SUB_LAST);
    assign sec_carry  = sub_tick && sub_wrap;
    assign min_carry  = sec_carry && (sec_q == 6'd59);
    assign hour_carry = min_carry && (min_q == 6'd59);
    assign day_carry  = hour_carry && (hour_q == 5'd23);
    assign adj_any    = i_sec_up | i_sec_down | i_min_up | i_min_down | i_hour_up | i_hour_down;

    assign sec_inc  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    assign min_inc  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    assign hour_inc = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;

    always_comb begin
        presc_d = presc_q;
        sub_d   = sub_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        alarm_d = 1'b0;
        day_d   = 1'b0;

        if (i_run) begin
            presc_d = sub_tick ? '0 : presc_q + 1'b1;
        end

        if (i_load) begin
            presc_d = '0;
            sub_d   = '0;
            sec_d   = (i_ld_sec  <= 6'd59) ? i_ld_sec  : 6'd0;
            min_d   = (i_ld_min  <= 6'd59) ? i_ld_min  : 6'd0;
            hour_d  = (i_ld_hour <= 5'd23) ? i_ld_hour : 5'd0;
        end else begin
            if (sub_tick) begin
                sub_d = sub_wrap ? '0 : sub_q + 1'b1;
            end
            // Any adjust strobe owns the time fields this cycle; the cascade carry is lost.
            if (adj_any) begin
                sec_d  = step60(sec_q,  i_sec_up,  i_sec_down);
                min_d  = step60(min_q,  i_min_up,  i_min_down);
                hour_d = step24(hour_q, i_hour_up, i_hour_down);
            end else begin
                if (sec_carry) begin
                    sec_d = sec_inc;
                end
                if (min_carry) begin
                    min_d = min_inc;
                end
                if (hour_carry) begin
                    hour_d = hour_inc;
                end
                alarm_d = min_carry && i_alarm_en &&
                          (hour_d == i_alarm_hour) && (min_d == i_alarm_min);
                day_d   = day_carry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q <= '0;
            sub_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            alarm_q <= 1'b0;
            day_q   <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            sub_q   <= sub_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            alarm_q <= alarm_d;
            day_q   <= day_d;
            blank_q <= 1'b0;
        end
    end

    // blank_q holds the displayed hour at 0 for the cycle after a reset edge, even in 12 h mode.
    always_comb begin
        o_hour_disp = hour_q;
        o_pm        = 1'b0;
        if (blank_q) begin
            o_hour_disp = 5'd0;
        end else if (i_mode12) begin
            o_pm = (hour_q >= 5'd12);
            if (hour_q == 5'd0) begin
                o_hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                o_hour_disp = hour_q - 5'd12;
            end
        end
    end

    assign o_sub      = sub_q;
    assign o_sec      = sec_q;
    assign o_min      = min_q;
    assign o_hour     = hour_q;
    assign o_alarm    = alarm_q;
    assign o_day_tick = day_q;

endmodule
